// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, valid/ready on both sides.
// Optional two's-complement support is compiled in with `define SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         signed_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t         r_state;
  state_t         w_state_next;
  logic           w_accept;
  logic           w_last_step;
  logic           w_div0;

  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  // Top bit of P is always 0 between steps, so only the low N bits are stored.
  logic [N-1:0]   r_p;

  logic [N:0]     w_p_shift;
  logic [N:0]     w_p_sub;
  logic [N-1:0]   w_p_step;
  logic [N-1:0]   w_a_step;

  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic [N-1:0]   w_q_final;
  logic [N-1:0]   w_r_final;

  logic [N-1:0]   r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_dbz;

  assign w_div0 = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic w_ovf_in;
  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf_pend;
  logic r_ovf;

  assign w_a_neg  = signed_op & dividend[N-1];
  assign w_b_neg  = signed_op & divisor[N-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor : divisor;
  assign w_ovf_in = signed_op && (dividend == MIN_VAL) && (divisor == '1);

  // Signs are applied on the same edge that loads the result registers.
  assign w_q_final = r_ovf_pend ? MIN_VAL :
                     (r_neg_q ? -w_a_step : w_a_step);
  assign w_r_final = r_ovf_pend ? '0 :
                     (r_neg_r ? -w_p_step : w_p_step);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_ovf_pend <= w_ovf_in;
      end
      if (w_accept && w_div0) begin
        r_ovf <= 1'b0;
      end else if (w_last_step) begin
        r_ovf <= r_ovf_pend;
      end
    end
  end

  assign overflow = r_ovf;
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = signed_op;
  assign w_a_mag   = dividend;
  assign w_b_mag   = divisor;
  assign w_q_final = w_a_step;
  assign w_r_final = w_p_step;
  assign overflow  = 1'b0;
`endif

  // Restoring step: shift in next dividend bit, trial-subtract, keep or restore.
  assign w_p_shift = {r_p, r_a[N-1]};
  assign w_p_sub   = w_p_shift - {1'b0, r_b};
  assign w_p_step  = w_p_sub[N] ? w_p_shift[N-1:0] : w_p_sub[N-1:0];
  assign w_a_step  = {r_a[N-2:0], ~w_p_sub[N]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = w_div0 ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(N - 1)) begin
          w_last_step  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_a_mag;
        r_b   <= w_b_mag;
        r_p   <= '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_a   <= w_a_step;
        r_p   <= w_p_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept && w_div0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end else if (w_last_step) begin
        r_quotient  <= w_q_final;
        r_remainder <= w_r_final;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at N=8; signed cases follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         signed_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .signed_op  (signed_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and return just after the acceptance edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int waited;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("issue a=%0h b=%0h signed=%0b", a, b, s);
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    int edges;
    edges = 0;
    while (!out_valid && edges < 40) begin
      chk({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
      tick();
      edges++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                              input logic dbz, input logic ovf);
    chk({tag, "_q"}, {24'd0, quotient}, {24'd0, q});
    chk({tag, "_r"}, {24'd0, remainder}, {24'd0, r});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, dbz});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
    $display("result %s q=%0h r=%0h dbz=%0b ovf=%0b", tag, quotient, remainder, div_by_zero, overflow);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rel_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s, input int lat, input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic dbz, input logic ovf);
    issue(a, b, s);
    wait_done(tag, lat);
    check_result(tag, q, r, dbz, ovf);
    release_result(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_op = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_result("rst", 8'd0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 100/10 with consumer always ready
    out_ready = 1'b1;
    issue(8'd100, 8'd10, 1'b0);
    wait_done("d100_10", 8);
    check_result("d100_10", 8'd10, 8'd0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    chk("d100_10_drop", {31'd0, out_valid}, 32'd0);

    // 255/5 then 16/3 with new operands waiting during DONE
    issue(8'd255, 8'd5, 1'b0);
    wait_done("d255_5", 8);
    check_result("d255_5", 8'd51, 8'd0, 1'b0, 1'b0);
    dividend  = 8'd16;
    divisor   = 8'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_q_held", {24'd0, quotient}, 32'd51);
    run_div("d16_3", 8'd16, 8'd3, 1'b0, 8, 8'd5, 8'd1, 1'b0, 1'b0);

    // divide by zero
    run_div("d77_0", 8'd77, 8'd0, 1'b0, 0, 8'hFF, 8'd77, 1'b1, 1'b0);

    // consumer stall for 5 cycles in DONE
    issue(8'd200, 8'd9, 1'b0);
    wait_done("d200_9", 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_result("stall", 8'd22, 8'd2, 1'b0, 1'b0);
    end
    release_result("d200_9");

    // boundary values
    run_div("d255_255", 8'd255, 8'd255, 1'b0, 8, 8'd1, 8'd0, 1'b0, 1'b0);
    run_div("d5_200", 8'd5, 8'd200, 1'b0, 8, 8'd0, 8'd5, 1'b0, 1'b0);
    run_div("d255_1", 8'd255, 8'd1, 1'b0, 8, 8'd255, 8'd0, 1'b0, 1'b0);

    // reset during the fourth step aborts the operation
    issue(8'd200, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_result("abort", 8'd0, 8'd0, 1'b0, 1'b0);
    run_div("d200_7", 8'd200, 8'd7, 1'b0, 8, 8'd28, 8'd4, 1'b0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m7_2", 8'hF9, 8'd2, 1'b1, 8, 8'hFD, 8'hFF, 1'b0, 1'b0);
    run_div("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8, 8'h80, 8'h00, 1'b0, 1'b1);
    run_div("s_7_m2", 8'd7, 8'hFE, 1'b1, 8, 8'hFD, 8'h01, 1'b0, 1'b0);
    run_div("s_m7_0", 8'hF9, 8'd0, 1'b1, 0, 8'hFF, 8'hF9, 1'b1, 1'b0);
    run_div("u_249_2", 8'hF9, 8'd2, 1'b0, 8, 8'd124, 8'd1, 1'b0, 1'b0);
`else
    // signed_op has no effect in the unsigned-only build
    run_div("u_249_2", 8'hF9, 8'd2, 1'b1, 8, 8'd124, 8'd1, 1'b0, 1'b0);
    run_div("u_128_255", 8'h80, 8'hFF, 1'b1, 8, 8'd0, 8'h80, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
